// File: rtl/irq_req_ack.sv
// irq_req_ack: requester side of the 27-channel A/B/C priority interrupt
// controller. It latches source events into a sticky pending register and
// presents the masked pending set as registered A/B/C request vectors. After
// a settle interval it samples the controller's bus grant and channel code,
// issues a one-cycle one-hot acknowledge, and retires the winning pending bit.
// Optional: define IRQ_REQ_ACK_CNT_EN to build a saturating acknowledge
// counter on ack_cnt. Without it, ack_cnt is tied to zero.
module irq_req_ack #(
  parameter int SETTLE_CYC = 2,  // 1..15
  parameter int ACK_GAP    = 1   // 0..15
) (
  input  logic        CK,
  input  logic        RN,
  input  logic [26:0] src_req,
  input  logic [26:0] mask,
  output logic [8:0]  req_a,
  output logic [8:0]  req_b,
  output logic [8:0]  req_c,
  input  logic [2:0]  grant_bus,
  input  logic [3:0]  grant_chan,
  output logic [26:0] ack,
  output logic        ack_valid,
  output logic [4:0]  ack_id,
  output logic        busy,
  output logic        err,
  output logic [15:0] ack_cnt
);

  typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, ACK, GAP} state_t;

  state_t      state, nxt;
  logic [26:0] pending;
  logic [26:0] live;
  logic [26:0] req_q;
  logic [3:0]  cnt;
  logic [1:0]  sbus;
  logic [4:0]  sidx;
  logic        grant_ok;

  assign live  = pending & ~mask;
  assign req_a = req_q[8:0];
  assign req_b = req_q[17:9];
  assign req_c = req_q[26:18];
  assign busy  = (state != IDLE);

  // Decode the controller grant against the frozen request snapshot.
  // Bus A has priority over B, B over C, when several enables are seen.
  always_comb begin
    sbus = 2'd0;
    if (grant_bus[0])      sbus = 2'd0;
    else if (grant_bus[1]) sbus = 2'd1;
    else if (grant_bus[2]) sbus = 2'd2;
    sidx     = 5'(sbus) * 5'd9 + {1'b0, grant_chan};
    grant_ok = 1'b0;
    if ((grant_bus != 3'b000) && (grant_chan <= 4'd8))
      grant_ok = req_q[sidx];
  end

  // State register.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) state <= IDLE;
    else     state <= nxt;
  end

  // Next-state logic.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (live != '0) nxt = SETTLE;
      SETTLE:  if (cnt == 4'd0) nxt = SAMPLE;
      SAMPLE:  nxt = grant_ok ? ACK : IDLE;
      ACK:     nxt = (ACK_GAP > 0) ? GAP : IDLE;
      GAP:     if (cnt == 4'd0) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Pending set/clear: a new event on the acknowledged bit wins over the clear.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) pending <= '0;
    else     pending <= (pending & ~((state == ACK) ? ack : 27'd0)) | src_req;
  end

  // Request snapshot, interval counter, acknowledge and error registers.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      req_q     <= '0;
      cnt       <= '0;
      ack       <= '0;
      ack_valid <= 1'b0;
      ack_id    <= '0;
      err       <= 1'b0;
    end else begin
      ack       <= '0;
      ack_valid <= 1'b0;
      case (state)
        IDLE: begin
          req_q <= live;
          cnt   <= 4'(SETTLE_CYC - 1);
        end
        SETTLE: if (cnt != 4'd0) cnt <= cnt - 4'd1;
        SAMPLE: begin
          if (grant_ok) begin
            ack       <= 27'd1 << sidx;
            ack_valid <= 1'b1;
            ack_id    <= sidx;
          end else begin
            err <= 1'b1;
          end
        end
        ACK:  cnt <= 4'(ACK_GAP - 1);
        GAP:  if (cnt != 4'd0) cnt <= cnt - 4'd1;
        default: ;
      endcase
    end
  end

`ifdef IRQ_REQ_ACK_CNT_EN
  logic [15:0] cnt_q;
  assign ack_cnt = cnt_q;

  // Saturating count of acknowledges issued.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN)                                cnt_q <= '0;
    else if (ack_valid && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
  end
`else
  assign ack_cnt = 16'h0000;
`endif

endmodule

// File: doc/irq_req_ack.md
Name: irq_req_ack

Overview:
- Requester-side companion to the team's 27-channel priority interrupt controller.
- The controller is combinational and organised as 3 buses (A, B, C) of 9 channels. This block sits on the other side of it.
- It latches interrupt events from 27 sources and presents masked pending requests to the controller as registered A/B/C request vectors.
- After a settle interval it samples the controller's bus-grant and channel code, decodes them to a one-hot acknowledge, and retires the winning pending bit.

Parameters:
- SETTLE_CYC, 2, cycles the request vectors are held stable before sampling the grant (legal 1..15).
- ACK_GAP, 1, idle cycles after an acknowledge before the next request snapshot (legal 0..15).

Ports:
- CK  in  1  clock, rising edge.
- RN  in  1  reset, asynchronous, active-low.
- src_req  in  27  event inputs. Bit index = bus*9 + chan; bus 0=A, 1=B, 2=C.
- mask  in  27  1 = source masked. The bit stays pending but is not presented.
- req_a  out  9  registered request vector, bus A, to controller.
- req_b  out  9  registered request vector, bus B, to controller.
- req_c  out  9  registered request vector, bus C, to controller.
- grant_bus  in  3  controller bus enables. Bit0 = A, bit1 = B, bit2 = C.
- grant_chan  in  4  controller winning channel, binary 0..8.
- ack  out  27  one-cycle one-hot acknowledge to sources.
- ack_valid  out  1  high in the same cycle as ack.
- ack_id  out  5  bus*9 + chan of the last acknowledge. Held until the next acknowledge.
- busy  out  1  FSM is not in IDLE.
- err  out  1  sticky grant-protocol error.
- ack_cnt  out  16  acknowledge counter (see Optional Feature).

Behaviour:
- Reset (RN low, asynchronous): pending=0, req_a/b/c=0, ack=0, ack_valid=0, ack_id=0, busy=0, err=0, ack_cnt=0, FSM=IDLE. Reset mid-operation aborts any transaction; no ack is issued.
- Pending register (27 bits): a bit sets on any cycle its src_req is 1 (level-sensitive, sticky). It clears only in ACK for the acknowledged index. If set and clear coincide on one bit, set wins and the bit stays pending.
- FSM states: IDLE, SETTLE, SAMPLE, ACK, GAP.
- IDLE:
  - Each cycle, req_{a,b,c} <= pending & ~mask.
  - If (pending & ~mask) != 0, go to SETTLE with cnt = SETTLE_CYC-1.
- SETTLE:
  - req vectors are frozen.
  - cnt decrements; at cnt==0 go to SAMPLE.
  - Total hold before sampling is SETTLE_CYC cycles.
- SAMPLE:
  - Select bus = lowest set bit of grant_bus (A > B > C). Idx = bus*9 + grant_chan.
  - Valid if all hold: grant_bus != 0, grant_chan <= 8, the idx bit was set in the frozen req vector.
  - Valid: go to ACK.
  - Invalid: err <= 1, go to IDLE; pending is untouched.
- ACK (exactly one cycle):
  - ack[idx]=1, ack_valid=1, ack_id<=idx, pending[idx] cleared (subject to set-wins).
  - Go to GAP if ACK_GAP > 0, else IDLE.
- GAP: hold ACK_GAP cycles with req vectors still frozen, then go to IDLE.
- Vector refresh: req vectors refresh only in IDLE, so the controller sees at most a one-cycle-late image of pending.
- Latency: from a src_req assertion in IDLE to ack is 1 (pending) + 1 (req reg) + SETTLE_CYC + 1 (SAMPLE) cycles. With defaults: ack is asserted 5 cycles after the src_req edge.
- busy = (state != IDLE).
- err clears only on reset.
- Mask changes during SETTLE/SAMPLE do not affect the frozen vectors or the validity check.

Optional Feature:
- Macro: IRQ_REQ_ACK_CNT_EN.
- Defined: ack_cnt increments by 1 on every ack_valid cycle, saturates at 16'hFFFF, and resets to 0.
- Undefined: no counter logic; ack_cnt is tied to 16'h0000.

Test Plan:
- Reset with RN low mid-SETTLE, all outputs checked -> all 0, FSM IDLE, no ack after RN rises with src_req=0.
- src_req[12] (bus B, chan 3) pulsed 1 cycle, controller model returns grant_bus=3'b010, grant_chan=3 -> req_b=9'h008; ack[12] high exactly 5 cycles after pulse; ack_id=12; pending[12] clear; busy low after ACK_GAP.
- src_req[0] and src_req[26] set together, model grants A/0 first, then C/8 -> two acks in order idx 0 then 26, separated by GAP+IDLE+settle (5 cycles with defaults).
- mask[5]=1 with src_req[5]=1 -> no request presented, no ack, busy=0. Clear mask -> ack[5] follows.
- Model returns grant_chan=4'd9 or grant_bus=0 -> err=1 sticky, no ack, pending retained, FSM retries on the next IDLE.
- src_req[7] re-asserted in the ACK cycle for idx 7 -> pending[7] stays set, second ack[7] issued. With IRQ_REQ_ACK_CNT_EN defined, ack_cnt=2.
